// File: rtl/pc_run_sequencer_if.sv
// Run-sequencer bundle: decoder/ALU controls and the start request in, PC and run status out.
// Latency: n/a (wiring only).
// Backpressure: none; Stall on the bundle holds the PC.
// Ports: Start, Halt, Stall, BranchTaken, BranchTarget (driven by master);
//        Pc, CountEn, Running, Done, CycleCount, Timeout (driven by slave).
interface pc_run_sequencer_if #(
   parameter int PC_W  = 10,
   parameter int CYC_W = 16
);
   logic             Start;
   logic             Halt;
   logic             Stall;
   logic             BranchTaken;
   logic [PC_W-1:0]  BranchTarget;
   logic [PC_W-1:0]  Pc;
   logic             CountEn;
   logic             Running;
   logic             Done;
   logic [CYC_W-1:0] CycleCount;
   logic             Timeout;

   modport master (
      output Start, Halt, Stall, BranchTaken, BranchTarget,
      input  Pc, CountEn, Running, Done, CycleCount, Timeout
   );

   modport slave (
      input  Start, Halt, Stall, BranchTaken, BranchTarget,
      output Pc, CountEn, Running, Done, CycleCount, Timeout
   );
endinterface

// File: rtl/pc_run_sequencer.sv
// Run controller and PC owner: IDLE -> ARMED (Start high) -> RUN (Start low) -> DONE (Halt).
// Latency: first RUN cycle shows START_ADDR one cycle after Start is sampled low; Done one cycle after Halt.
// Backpressure: Stall holds Pc and suppresses Halt/branch; Start during RUN aborts back to ARMED.
// Ports: Clk, Reset_n (async active-low), bus (pc_run_sequencer_if.slave).
// Optional: define PC_RUN_SEQUENCER_WATCHDOG_EN to end a run in DONE with Timeout=1
//           once CycleCount reaches MAX_CYCLES; otherwise Timeout is tied 0.
module pc_run_sequencer #(
   parameter int PC_W       = 10,
   parameter int START_ADDR = 0,
   parameter int CYC_W      = 16,
   parameter int MAX_CYCLES = 50000
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   pc_run_sequencer_if.slave     bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

   state_t           state_q, state_d;
   logic [PC_W-1:0]  pc_q;
   logic [CYC_W-1:0] cyc_q;
   logic             wd_fire;

`ifdef PC_RUN_SEQUENCER_WATCHDOG_EN
   logic timeout_q;

   // Compared against the count before this cycle's increment.
   assign wd_fire = (state_q == RUN) && (cyc_q == CYC_W'(MAX_CYCLES));

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         timeout_q <= 1'b0;
      end else if (wd_fire && !bus.Start) begin
         timeout_q <= 1'b1;
      end else if (state_q == DONE && bus.Start) begin
         timeout_q <= 1'b0;
      end
   end

   assign bus.Timeout = timeout_q;
`else
   wire [CYC_W-1:0] unused_max_cycles = CYC_W'(MAX_CYCLES);

   assign wd_fire     = 1'b0;
   assign bus.Timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; in RUN an abort beats everything, and a stalled
   // instruction cannot halt because it does not retire.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.Start)  state_d = ARMED;
         ARMED:   if (!bus.Start) state_d = RUN;
         RUN: begin
            if (bus.Start)                           state_d = ARMED;
            else if (wd_fire || (!bus.Stall && bus.Halt)) state_d = DONE;
         end
         DONE:    if (bus.Start)  state_d = ARMED;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from registered state; only CountEn sees the live controls.
   always_comb begin
      bus.Running = (state_q == RUN);
      bus.Done    = (state_q == DONE);
      bus.CountEn = (state_q == RUN) & ~bus.Stall & ~bus.Halt & ~bus.Start;
   end

   // PC and cycle counter
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pc_q  <= START_PC;
         cyc_q <= '0;
      end else begin
         unique case (state_q)
            ARMED: begin
               if (!bus.Start) begin
                  pc_q  <= START_PC;
                  cyc_q <= '0;
               end
            end
            RUN: begin
               // Every RUN cycle counts, stalls and the halt cycle included.
               if (cyc_q != '1) cyc_q <= cyc_q + 1'b1;
               if (bus.Start) begin
                  pc_q <= START_PC;
               end else if (!wd_fire && !bus.Stall && !bus.Halt) begin
                  pc_q <= bus.BranchTaken ? bus.BranchTarget : pc_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.Pc         = pc_q;
   assign bus.CycleCount = cyc_q;

endmodule

// File: tb/tb_pc_run_sequencer.sv
// Directed bench for pc_run_sequencer: driver pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_run_sequencer;
   localparam int PC_W   = 10;
   localparam int CYC_W  = 16;
   localparam int TB_MAX = 40;

   typedef struct {
      int              tag;
      logic [PC_W-1:0] pc;
      logic            run;
      logic            done;
      logic            ce;
      int              cc;   // -1: not checked
      logic            to;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];

   pc_run_sequencer_if #(.PC_W(PC_W), .CYC_W(CYC_W)) bus ();

   pc_run_sequencer #(
      .PC_W(PC_W), .START_ADDR(0), .CYC_W(CYC_W), .MAX_CYCLES(TB_MAX)
   ) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .bus(bus)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   // Monitor
   always @(negedge Clk) begin
      while (sb_q.size() > 0 && sb_q[0].tag < cyc) begin
         failures++;
         checks++;
         $display("FAIL stale_exp tag=%0d now=%0d", sb_q[0].tag, cyc);
         void'(sb_q.pop_front());
      end
      if (sb_q.size() > 0 && sb_q[0].tag == cyc) begin
         exp_t e;
         e = sb_q.pop_front();
         checks++;
         if (bus.Pc !== e.pc || bus.Running !== e.run || bus.Done !== e.done ||
             bus.CountEn !== e.ce || bus.Timeout !== e.to ||
             (e.cc >= 0 && int'(bus.CycleCount) != e.cc)) begin
            failures++;
            $display("FAIL cyc%0d got pc=%h run=%b done=%b ce=%b cc=%0d to=%b want pc=%h run=%b done=%b ce=%b cc=%0d to=%b",
                     cyc, bus.Pc, bus.Running, bus.Done, bus.CountEn, bus.CycleCount, bus.Timeout,
                     e.pc, e.run, e.done, e.ce, e.cc, e.to);
         end
      end
   end

   // One cycle: apply inputs just after the edge, expect these outputs during the cycle.
   task automatic drv(input logic s, input logic h, input logic st, input logic bt,
                      input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] e_pc,
                      input logic e_run, input logic e_done, input logic e_ce,
                      input int e_cc, input logic e_to);
      exp_t e;
      @(posedge Clk);
      #1;
      bus.Start = s; bus.Halt = h; bus.Stall = st;
      bus.BranchTaken = bt; bus.BranchTarget = tgt;
      e.tag = cyc; e.pc = e_pc; e.run = e_run; e.done = e_done;
      e.ce = e_ce; e.cc = e_cc; e.to = e_to;
      sb_q.push_back(e);
   endtask

   task automatic run(input int pc, input int cc);
      drv(0, 0, 0, 0, '0, PC_W'(pc), 1, 0, 1, cc, 0);
   endtask

   initial begin
      bus.Start = 0; bus.Halt = 0; bus.Stall = 0; bus.BranchTaken = 0; bus.BranchTarget = '0;

      // Reset state
      repeat (2) drv(0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0);
      Reset_n = 1'b1;

      // Start high 3 cycles then low; run from 0
      repeat (3) drv(1, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0);
      drv(0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0);
      for (int p = 0; p < 5; p++) run(p, p);

      // Branch at 5 to 0x3F0, then wrap 0x3FF -> 0
      drv(0, 0, 0, 1, 10'h3F0, 10'd5, 1, 0, 1, 5, 0);
      for (int k = 0; k < 16; k++) run(10'h3F0 + k, 6 + k);
      for (int p = 0; p < 7; p++) run(p, 22 + p);

      // Stalled halt at 7, then retiring halt
      drv(0, 1, 1, 0, '0, 10'd7, 1, 0, 0, 29, 0);
      drv(0, 1, 1, 0, '0, 10'd7, 1, 0, 0, 30, 0);
      drv(0, 1, 0, 0, '0, 10'd7, 1, 0, 0, 31, 0);
      drv(0, 0, 0, 0, '0, 10'd7, 0, 1, 0, 32, 0);
      drv(1, 0, 0, 0, '0, 10'd7, 0, 1, 0, 32, 0);
      drv(0, 0, 0, 0, '0, 10'd7, 0, 0, 0, 32, 0);

      // Abort at 12, restart from 0
      for (int p = 0; p < 12; p++) run(p, p);
      drv(1, 0, 0, 0, '0, 10'd12, 1, 0, 0, 12, 0);
      drv(0, 0, 0, 0, '0, 10'd0, 0, 0, 0, -1, 0);
      for (int p = 0; p < 20; p++) run(p, p);

      // Asynchronous reset mid-cycle at Pc=20
      drv(0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0);
      #2 Reset_n = 1'b0;
      drv(0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0);
      Reset_n = 1'b1;

      // Low-only Start stays idle; then a proper sequence runs
      repeat (3) drv(0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0);
      drv(0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0);
      run(0, 0);
      run(1, 1);
      drv(0, 1, 0, 0, '0, 10'd2, 1, 0, 0, 2, 0);
      drv(0, 0, 0, 0, '0, 10'd2, 0, 1, 0, 3, 0);

`ifdef PC_RUN_SEQUENCER_WATCHDOG_EN
      // Watchdog: no Halt, DONE with Timeout after MAX+1 RUN cycles
      drv(1, 0, 0, 0, '0, 10'd2, 0, 1, 0, 3, 0);
      drv(0, 0, 0, 0, '0, 10'd2, 0, 0, 0, 3, 0);
      for (int p = 0; p <= TB_MAX; p++) run(p, p);
      drv(0, 0, 0, 0, '0, PC_W'(TB_MAX), 0, 1, 0, TB_MAX + 1, 1);
      drv(1, 0, 0, 0, '0, PC_W'(TB_MAX), 0, 1, 0, TB_MAX + 1, 1);
      drv(0, 0, 0, 0, '0, PC_W'(TB_MAX), 0, 0, 0, TB_MAX + 1, 0);
`endif

      // Drain scoreboard with a bound
      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge Clk);
      if (sb_q.size() > 0) begin
         failures++;
         checks++;
         $display("FAIL drain left=%0d want=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
